dm_port_arbiter: RTL and testbench

//  Two-requester arbiter/sequencer in front of the word-addressed data memory.

---
 rtl/dm_port_arbiter_if.sv | 48 ++++
 rtl/dm_port_arbiter.sv | 130 +++++++++++++
 tb/tb_dm_port_arbiter.sv | 398 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_port_arbiter_if.sv
// Two-port data-memory request bundle plus the shared DM-side wiring.
// The slave modport is the arbiter; the master modport faces requesters and DM.
interface dm_port_arbiter_if;
    logic        a_req;
    logic        a_we;
    logic [2:0]  a_op;
    logic [31:0] a_addr;
    logic [31:0] a_wdata;
    logic        a_ready;
    logic        a_rvalid;
    logic [31:0] a_rdata;
    logic        a_err;

    logic        b_req;
    logic        b_we;
    logic [2:0]  b_op;
    logic [31:0] b_addr;
    logic [31:0] b_wdata;
    logic        b_ready;
    logic        b_rvalid;
    logic [31:0] b_rdata;
    logic        b_err;

    logic [31:0] dm_addr;
    logic [31:0] dm_wd;
    logic        dm_memwrite;
    logic [31:0] dm_in_src;
    logic [31:0] dm_out_src;
    logic [31:0] dm_data;

    modport slave (
        input  a_req, a_we, a_op, a_addr, a_wdata,
        output a_ready, a_rvalid, a_rdata, a_err,
        input  b_req, b_we, b_op, b_addr, b_wdata,
        output b_ready, b_rvalid, b_rdata, b_err,
        output dm_addr, dm_wd, dm_memwrite, dm_in_src, dm_out_src,
        input  dm_data
    );

    modport master (
        output a_req, a_we, a_op, a_addr, a_wdata,
        input  a_ready, a_rvalid, a_rdata, a_err,
        output b_req, b_we, b_op, b_addr, b_wdata,
        input  b_ready, b_rvalid, b_rdata, b_err,
        input  dm_addr, dm_wd, dm_memwrite, dm_in_src, dm_out_src,
        output dm_data
    );
endinterface

// File: rtl/dm_port_arbiter.sv
// Two-port data-memory arbiter: A priority, B starvation-bounded, 2-stage pipe.
// Optional alignment/op checking is enabled by defining DM_ALIGN_CHECK_EN.
module dm_port_arbiter #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              reset,
    dm_port_arbiter_if.slave  bus
);
    localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

    logic [3:0]  hold_q, hold_d;

    logic        s1_valid_q, s1_valid_d;
    logic        s1_owner_q, s1_owner_d;
    logic        s1_we_q, s1_we_d;
    logic        s1_mw_q, s1_mw_d;
    logic        s1_err_q, s1_err_d;
    logic [2:0]  s1_op_q, s1_op_d;
    logic [31:0] s1_addr_q, s1_addr_d;
    logic [31:0] s1_wd_q, s1_wd_d;

    logic        s2_valid_q, s2_valid_d;
    logic        s2_owner_q, s2_owner_d;
    logic        s2_err_q, s2_err_d;
    logic [31:0] s2_rdata_q, s2_rdata_d;

    logic        gnt_a, gnt_b, accept;
    logic        sel_we, sel_err;
    logic [2:0]  sel_op;
    logic [31:0] sel_addr, sel_wd;

    always_comb begin
        gnt_a  = bus.a_req && reset
                 && !(bus.b_req && (hold_q == HOLD_MAX));
        gnt_b  = bus.b_req && reset && !gnt_a;
        accept = gnt_a || gnt_b;

        sel_we   = gnt_b ? bus.b_we    : bus.a_we;
        sel_op   = gnt_b ? bus.b_op    : bus.a_op;
        sel_addr = gnt_b ? bus.b_addr  : bus.a_addr;
        sel_wd   = gnt_b ? bus.b_wdata : bus.a_wdata;

`ifdef DM_ALIGN_CHECK_EN
        sel_err = (sel_op > 3'd4)
                  || ((sel_op == 3'd0) && (sel_addr[1:0] != 2'b00))
                  || (((sel_op == 3'd1) || (sel_op == 3'd2)) && sel_addr[0]);
`else
        sel_err = 1'b0;
`endif

        // B's wait counter only runs while B is actually waiting
        hold_d = hold_q;
        if (!bus.b_req || gnt_b) begin
            hold_d = 4'd0;
        end else if (gnt_a && (hold_q != HOLD_MAX)) begin
            hold_d = hold_q + 4'd1;
        end

        s1_valid_d = accept;
        s1_owner_d = gnt_b;
        s1_we_d    = accept && sel_we;
        s1_err_d   = accept && sel_err;
        s1_mw_d    = accept && sel_we && !sel_err;
        s1_op_d    = accept ? sel_op   : 3'd0;
        s1_addr_d  = accept ? sel_addr : 32'd0;
        s1_wd_d    = accept ? sel_wd   : 32'd0;

        s2_valid_d = s1_valid_q;
        s2_owner_d = s1_owner_q;
        s2_err_d   = s1_err_q;
        s2_rdata_d = (s1_valid_q && !s1_we_q && !s1_err_q)
                     ? bus.dm_data : 32'd0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_q     <= 4'd0;
            s1_valid_q <= 1'b0;
            s1_owner_q <= 1'b0;
            s1_we_q    <= 1'b0;
            s1_mw_q    <= 1'b0;
            s1_err_q   <= 1'b0;
            s1_op_q    <= 3'd0;
            s1_addr_q  <= 32'd0;
            s1_wd_q    <= 32'd0;
            s2_valid_q <= 1'b0;
            s2_owner_q <= 1'b0;
            s2_err_q   <= 1'b0;
            s2_rdata_q <= 32'd0;
        end else begin
            hold_q     <= hold_d;
            s1_valid_q <= s1_valid_d;
            s1_owner_q <= s1_owner_d;
            s1_we_q    <= s1_we_d;
            s1_mw_q    <= s1_mw_d;
            s1_err_q   <= s1_err_d;
            s1_op_q    <= s1_op_d;
            s1_addr_q  <= s1_addr_d;
            s1_wd_q    <= s1_wd_d;
            s2_valid_q <= s2_valid_d;
            s2_owner_q <= s2_owner_d;
            s2_err_q   <= s2_err_d;
            s2_rdata_q <= s2_rdata_d;
        end
    end

    always_comb begin
        bus.a_ready = gnt_a;
        bus.b_ready = gnt_b;

        bus.a_rvalid = s2_valid_q && !s2_owner_q;
        bus.b_rvalid = s2_valid_q && s2_owner_q;
        bus.a_rdata  = bus.a_rvalid ? s2_rdata_q : 32'd0;
        bus.b_rdata  = bus.b_rvalid ? s2_rdata_q : 32'd0;
        bus.a_err    = bus.a_rvalid && s2_err_q;
        bus.b_err    = bus.b_rvalid && s2_err_q;

        bus.dm_addr     = s1_addr_q;
        bus.dm_wd       = s1_wd_q;
        bus.dm_memwrite = s1_mw_q;
        bus.dm_out_src  = {29'd0, s1_op_q};
        // halves select lane code 1, bytes code 2, everything else word
        case (s1_op_q)
            3'd1, 3'd2: bus.dm_in_src = 32'd1;
            3'd3, 3'd4: bus.dm_in_src = 32'd2;
            default:    bus.dm_in_src = 32'd0;
        endcase
    end
endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed self-checking bench for dm_port_arbiter with a behavioural DM.
// Compile with DM_ALIGN_CHECK_EN defined to exercise the alignment checks.
module tb_dm_port_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    dm_port_arbiter_if bus();

    dm_port_arbiter #(.MAX_HOLD(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mem [0:63];
    logic        pl_we = 1'b0;
    logic [5:0]  pl_idx = 6'd0;
    logic [31:0] pl_data = 32'd0;

    logic [31:0] rd_w, rd_sh;
    logic [15:0] rd_h;
    logic [7:0]  rd_b;

    // Behavioural DM: lane-aware store, sign/zero-extending read
    always @(posedge clk) begin
        if (pl_we) begin
            mem[pl_idx] <= pl_data;
        end else if (bus.dm_memwrite) begin
            case (bus.dm_in_src)
                32'd1: begin
                    if (bus.dm_addr[1])
                        mem[bus.dm_addr[7:2]][31:16] <= bus.dm_wd[15:0];
                    else
                        mem[bus.dm_addr[7:2]][15:0] <= bus.dm_wd[15:0];
                end
                32'd2: begin
                    case (bus.dm_addr[1:0])
                        2'd0: mem[bus.dm_addr[7:2]][7:0]   <= bus.dm_wd[7:0];
                        2'd1: mem[bus.dm_addr[7:2]][15:8]  <= bus.dm_wd[7:0];
                        2'd2: mem[bus.dm_addr[7:2]][23:16] <= bus.dm_wd[7:0];
                        default: mem[bus.dm_addr[7:2]][31:24] <= bus.dm_wd[7:0];
                    endcase
                end
                default: mem[bus.dm_addr[7:2]] <= bus.dm_wd;
            endcase
        end
    end

    always_comb begin
        rd_w  = mem[bus.dm_addr[7:2]];
        rd_h  = bus.dm_addr[1] ? rd_w[31:16] : rd_w[15:0];
        rd_sh = rd_w >> {bus.dm_addr[1:0], 3'b000};
        rd_b  = rd_sh[7:0];
        case (bus.dm_out_src)
            32'd1:   bus.dm_data = {{16{rd_h[15]}}, rd_h};
            32'd2:   bus.dm_data = {16'd0, rd_h};
            32'd3:   bus.dm_data = {{24{rd_b[7]}}, rd_b};
            32'd4:   bus.dm_data = {24'd0, rd_b};
            default: bus.dm_data = rd_w;
        endcase
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        bus.a_req = 0; bus.a_we = 0; bus.a_op = 0;
        bus.a_addr = 0; bus.a_wdata = 0;
        bus.b_req = 0; bus.b_we = 0; bus.b_op = 0;
        bus.b_addr = 0; bus.b_wdata = 0;
    endtask

    task automatic drive_a(input logic we, input logic [2:0] op,
                           input logic [31:0] addr, input logic [31:0] wd);
        bus.a_req = 1; bus.a_we = we; bus.a_op = op;
        bus.a_addr = addr; bus.a_wdata = wd;
    endtask

    task automatic drive_b(input logic we, input logic [2:0] op,
                           input logic [31:0] addr, input logic [31:0] wd);
        bus.b_req = 1; bus.b_we = we; bus.b_op = op;
        bus.b_addr = addr; bus.b_wdata = wd;
    endtask

    task automatic preload(input logic [5:0] idx, input logic [31:0] d);
        pl_we = 1; pl_idx = idx; pl_data = d;
        step;
        pl_we = 0;
    endtask

    task automatic test_reset;
        drive_a(1, 0, 32'h10, 32'h1234);
        #1;
        n_tests++;
        if ({bus.a_ready, bus.b_ready, bus.a_rvalid, bus.b_rvalid,
             bus.dm_memwrite} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 00000",
                     {bus.a_ready, bus.b_ready, bus.a_rvalid,
                      bus.b_rvalid, bus.dm_memwrite});
        end
        n_tests++;
        if ({bus.dm_addr, bus.dm_wd, bus.dm_in_src, bus.dm_out_src}
            !== 128'd0) begin
            n_fail++;
            $display("FAIL reset_dm: got %h %h want 0 0",
                     bus.dm_addr, bus.dm_wd);
        end
        idle;
        step;
        reset = 1;
    endtask

    task automatic test_word;
        preload(6'd4, 32'h0);
        drive_a(1, 0, 32'h10, 32'hDEADBEEF);
        #1;
        n_tests++;
        if (bus.a_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL word_ready: got %b want 1", bus.a_ready);
        end
        step;
        n_tests++;
        if ({bus.dm_memwrite, bus.dm_addr, bus.dm_wd, bus.dm_in_src}
            !== {1'b1, 32'h10, 32'hDEADBEEF, 32'd0}) begin
            n_fail++;
            $display("FAIL word_s1: got mw=%b addr=%h wd=%h want 1 10 deadbeef",
                     bus.dm_memwrite, bus.dm_addr, bus.dm_wd);
        end
        drive_a(0, 0, 32'h10, 32'h0);
        step;
        n_tests++;
        if ({bus.a_rvalid, bus.a_rdata, bus.dm_memwrite}
            !== {1'b1, 32'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL word_st_resp: got v=%b d=%h mw=%b want 1 0 0",
                     bus.a_rvalid, bus.a_rdata, bus.dm_memwrite);
        end
        idle;
        step;
        n_tests++;
        if ({bus.a_rvalid, bus.b_rvalid, bus.a_rdata}
            !== {2'b10, 32'hDEADBEEF}) begin
            n_fail++;
            $display("FAIL word_ld_resp: got v=%b%b d=%h want 10 deadbeef",
                     bus.a_rvalid, bus.b_rvalid, bus.a_rdata);
        end
        step;
        n_tests++;
        if ({bus.a_rvalid, bus.dm_memwrite, bus.dm_addr} !== 34'd0) begin
            n_fail++;
            $display("FAIL word_idle: got v=%b mw=%b addr=%h want 0 0 0",
                     bus.a_rvalid, bus.dm_memwrite, bus.dm_addr);
        end
    endtask

    task automatic test_subword;
        preload(6'd4, 32'h0);
        drive_a(1, 3'd3, 32'h13, 32'hAB);
        step;
        n_tests++;
        if ({bus.dm_memwrite, bus.dm_in_src} !== {1'b1, 32'd2}) begin
            n_fail++;
            $display("FAIL byte_in_src: got mw=%b src=%0d want 1 2",
                     bus.dm_memwrite, bus.dm_in_src);
        end
        drive_a(0, 3'd3, 32'h13, 32'h0);
        step;
        drive_a(0, 3'd4, 32'h13, 32'h0);
        #1;
        n_tests++;
        if (bus.dm_out_src !== 32'd3) begin
            n_fail++;
            $display("FAIL byte_out_src: got %0d want 3", bus.dm_out_src);
        end
        step;
        idle;
        n_tests++;
        if ({bus.a_rvalid, bus.a_rdata} !== {1'b1, 32'hFFFFFFAB}) begin
            n_fail++;
            $display("FAIL byte_lb: got v=%b d=%h want 1 ffffffab",
                     bus.a_rvalid, bus.a_rdata);
        end
        step;
        n_tests++;
        if ({bus.a_rvalid, bus.a_rdata} !== {1'b1, 32'h000000AB}) begin
            n_fail++;
            $display("FAIL byte_lbu: got v=%b d=%h want 1 000000ab",
                     bus.a_rvalid, bus.a_rdata);
        end
        step;
        preload(6'd5, 32'h0);
        drive_a(1, 3'd1, 32'h16, 32'h8001);
        step;
        n_tests++;
        if ({bus.dm_memwrite, bus.dm_in_src} !== {1'b1, 32'd1}) begin
            n_fail++;
            $display("FAIL half_in_src: got mw=%b src=%0d want 1 1",
                     bus.dm_memwrite, bus.dm_in_src);
        end
        drive_a(0, 3'd1, 32'h16, 32'h0);
        step;
        drive_a(0, 3'd2, 32'h16, 32'h0);
        step;
        idle;
        n_tests++;
        if ({bus.a_rvalid, bus.a_rdata} !== {1'b1, 32'hFFFF8001}) begin
            n_fail++;
            $display("FAIL half_lh: got v=%b d=%h want 1 ffff8001",
                     bus.a_rvalid, bus.a_rdata);
        end
        step;
        n_tests++;
        if ({bus.a_rvalid, bus.a_rdata} !== {1'b1, 32'h00008001}) begin
            n_fail++;
            $display("FAIL half_lhu: got v=%b d=%h want 1 00008001",
                     bus.a_rvalid, bus.a_rdata);
        end
        step;
    endtask

    task automatic test_arbitration;
        logic [11:0] pat;
        logic        exp_b;
        pat = 12'b0010_0001_0000;
        preload(6'd16, 32'h1111AAAA);
        preload(6'd32, 32'h2222BBBB);
        drive_a(0, 0, 32'h40, 32'h0);
        drive_b(0, 0, 32'h80, 32'h0);
        for (int i = 0; i < 14; i++) begin
            #1;
            if (i < 12) begin
                n_tests++;
                if ({bus.a_ready, bus.b_ready} !== {!pat[i], pat[i]}) begin
                    n_fail++;
                    $display("FAIL arb_grant[%0d]: got a=%b b=%b want a=%b b=%b",
                             i, bus.a_ready, bus.b_ready, !pat[i], pat[i]);
                end
            end
            if (i >= 2) begin
                exp_b = pat[i-2];
                n_tests++;
                if ({bus.a_rvalid, bus.b_rvalid} !== {!exp_b, exp_b}
                    || (exp_b ? bus.b_rdata : bus.a_rdata)
                       !== (exp_b ? 32'h2222BBBB : 32'h1111AAAA)) begin
                    n_fail++;
                    $display("FAIL arb_resp[%0d]: got v=%b%b a=%h b=%h want v=%b%b",
                             i, bus.a_rvalid, bus.b_rvalid, bus.a_rdata,
                             bus.b_rdata, !exp_b, exp_b);
                end
            end
            step;
            if (i == 11) idle;
        end
    endtask

    task automatic test_reset_inflight;
        preload(6'd12, 32'hCAFEF00D);
        drive_a(1, 0, 32'h30, 32'h12345678);
        step;
        n_tests++;
        if (bus.dm_memwrite !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre_mw: got %b want 1", bus.dm_memwrite);
        end
        drive_a(0, 0, 32'h30, 32'h0);
        #1;
        reset = 0;
        #1;
        n_tests++;
        if ({bus.dm_memwrite, bus.a_ready, bus.dm_addr} !== 34'd0) begin
            n_fail++;
            $display("FAIL rst_async: got mw=%b rdy=%b addr=%h want 0 0 0",
                     bus.dm_memwrite, bus.a_ready, bus.dm_addr);
        end
        step;
        n_tests++;
        if ({bus.a_rvalid, bus.dm_memwrite} !== 2'b00) begin
            n_fail++;
            $display("FAIL rst_hold: got v=%b mw=%b want 0 0",
                     bus.a_rvalid, bus.dm_memwrite);
        end
        reset = 1;
        #1;
        n_tests++;
        if (bus.a_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_first_accept: got %b want 1", bus.a_ready);
        end
        step;
        idle;
        n_tests++;
        if (bus.a_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_no_resp: got %b want 0", bus.a_rvalid);
        end
        step;
        n_tests++;
        if ({bus.a_rvalid, bus.a_rdata, mem[12]}
            !== {1'b1, 32'hCAFEF00D, 32'hCAFEF00D}) begin
            n_fail++;
            $display("FAIL rst_mem_kept: got v=%b d=%h mem=%h want 1 cafef00d cafef00d",
                     bus.a_rvalid, bus.a_rdata, mem[12]);
        end
        step;
    endtask

    task automatic test_misaligned;
        logic        exp_mw, exp_err;
        logic [31:0] exp_mem;
`ifdef DM_ALIGN_CHECK_EN
        exp_mw = 0; exp_err = 1; exp_mem = 32'h55555555;
`else
        exp_mw = 1; exp_err = 0; exp_mem = 32'h0BADF00D;
`endif
        preload(6'd8, 32'h55555555);
        drive_a(1, 0, 32'h22, 32'h0BADF00D);
        step;
        idle;
        n_tests++;
        if ({bus.dm_memwrite, bus.dm_addr} !== {exp_mw, 32'h22}) begin
            n_fail++;
            $display("FAIL mis_mw: got mw=%b addr=%h want %b 22",
                     bus.dm_memwrite, bus.dm_addr, exp_mw);
        end
        step;
        n_tests++;
        if ({bus.a_rvalid, bus.a_err, bus.a_rdata, mem[8]}
            !== {1'b1, exp_err, 32'h0, exp_mem}) begin
            n_fail++;
            $display("FAIL mis_resp: got v=%b err=%b d=%h mem=%h want 1 %b 0 %h",
                     bus.a_rvalid, bus.a_err, bus.a_rdata, mem[8],
                     exp_err, exp_mem);
        end
        step;
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp [3];
        exp[0] = 32'hB0B0_0001;
        exp[1] = 32'hB0B0_0002;
        exp[2] = 32'hB0B0_0003;
        preload(6'd40, exp[0]);
        preload(6'd41, exp[1]);
        preload(6'd42, exp[2]);
        for (int i = 0; i < 6; i++) begin
            if (i < 3) drive_b(0, 0, 32'hA0 + 32'(4 * i), 32'h0);
            else idle;
            #1;
            if (i < 3) begin
                n_tests++;
                if ({bus.b_ready, bus.a_ready} !== 2'b10) begin
                    n_fail++;
                    $display("FAIL b2b_ready[%0d]: got b=%b a=%b want 1 0",
                             i, bus.b_ready, bus.a_ready);
                end
            end
            if (i >= 2) begin
                n_tests++;
                if (i < 5) begin
                    if ({bus.b_rvalid, bus.a_rvalid, bus.b_rdata}
                        !== {2'b10, exp[i-2]}) begin
                        n_fail++;
                        $display("FAIL b2b_resp[%0d]: got v=%b%b d=%h want 10 %h",
                                 i, bus.b_rvalid, bus.a_rvalid,
                                 bus.b_rdata, exp[i-2]);
                    end
                end else if ({bus.b_rvalid, bus.a_rvalid} !== 2'b00) begin
                    n_fail++;
                    $display("FAIL b2b_end: got v=%b%b want 00",
                             bus.b_rvalid, bus.a_rvalid);
                end
            end
            step;
        end
    endtask

    initial begin
        idle;
        step;
        test_reset;
        test_word;
        test_subword;
        test_arbitration;
        test_reset_inflight;
        test_misaligned;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
